// File: rtl/duc_path_if.sv
// -----------------------------------------------------------------------------
// duc_path_if : sample/command/output bundle for the duc_path upconverter.
//
// Signals (directions as seen by the DUT, modport slave):
//   i_valid            in   baseband sample offered
//   o_ready            out  sample accepted this cycle (handshake with i_valid)
//   i_data_i/i_data_q  in   signed I/Q baseband sample
//   i_interp_cmd_valid in   interpolation factor update strobe
//   i_interp_cmd_data  in   requested factor minus 1
//   o_valid            out  output sample valid
//   o_data             out  signed real upconverted sample (one bit wider)
//   o_lo_phase         out  LO phase index of o_data
//   o_underflow        out  one-cycle pulse when the sample stream runs dry
// The master modport is the sample source / output sink side.
// -----------------------------------------------------------------------------
interface duc_path_if #(
  parameter int INT_IN_DATA_WIDTH     = 20,
  parameter int INT_MAX_INTERPOLATION = 8
);
  localparam int CMD_W = $clog2(INT_MAX_INTERPOLATION);

  logic                                i_valid;
  logic                                o_ready;
  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_i;
  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_q;
  logic                                i_interp_cmd_valid;
  logic [CMD_W-1:0]                    i_interp_cmd_data;
  logic                                o_valid;
  logic signed [INT_IN_DATA_WIDTH:0]   o_data;
  logic [1:0]                          o_lo_phase;
  logic                                o_underflow;

  modport master (
    output i_valid, i_data_i, i_data_q, i_interp_cmd_valid, i_interp_cmd_data,
    input  o_ready, o_valid, o_data, o_lo_phase, o_underflow
  );

  modport slave (
    input  i_valid, i_data_i, i_data_q, i_interp_cmd_valid, i_interp_cmd_data,
    output o_ready, o_valid, o_data, o_lo_phase, o_underflow
  );
endinterface

// File: rtl/duc_path.sv
// -----------------------------------------------------------------------------
// duc_path : zero-order-hold interpolator followed by an fs/4 digital
// upconverter. Each accepted I/Q sample is repeated "factor" times; every
// output cycle the sample is mixed with a quarter-rate LO
// (phase 0:+I, 1:-Q, 2:-I, 3:+Q) producing one real sample.
//
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  duc_path_if.slave (sample handshake, factor command, outputs)
//
// o_ready is the only combinational output and depends solely on the FSM
// state and repeat counter; all other outputs are registered.
// -----------------------------------------------------------------------------
module duc_path #(
  parameter int INT_IN_DATA_WIDTH     = 20,
  parameter int INT_MAX_INTERPOLATION = 8
) (
  input  logic       clk,
  input  logic       rst,
  duc_path_if.slave  bus
);

  localparam int W  = INT_IN_DATA_WIDTH;
  localparam int CW = $clog2(INT_MAX_INTERPOLATION);
  // One extra bit so cmd+1 (up to 2^CW) is representable before clamping.
  localparam int FW = CW + 1;
  localparam logic [FW-1:0] FAC_MAX = FW'(INT_MAX_INTERPOLATION);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Requested factor (cmd+1), clamped to the maximum repeat factor.
  function automatic logic [FW-1:0] clamp_factor(input logic [CW-1:0] cmd);
    logic [FW-1:0] f;
    f = {1'b0, cmd} + FW'(1);
    if (f > FAC_MAX) begin
      f = FAC_MAX;
    end else begin
      f = f;
    end
    return f;
  endfunction

  // fs/4 mixer: I*cos - Q*sin. Widening by one bit makes -(-2^(W-1)) exact.
  function automatic logic signed [W:0] lo_mix(
    input logic signed [W-1:0] di,
    input logic signed [W-1:0] dq,
    input logic [1:0]          ph
  );
    logic signed [W:0] ie;
    logic signed [W:0] qe;
    logic signed [W:0] r;
    ie = {di[W-1], di};
    qe = {dq[W-1], dq};
    case (ph)
      2'd0:    r = ie;
      2'd1:    r = -qe;
      2'd2:    r = -ie;
      2'd3:    r = qe;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [FW-1:0]         pend_q, pend_d;
  logic [FW-1:0]         act_q, act_d;
  logic [FW-1:0]         cnt_q, cnt_d;
  logic signed [W-1:0]   hold_i_q, hold_i_d;
  logic signed [W-1:0]   hold_q_q, hold_q_d;
  logic                  o_valid_q, o_valid_d;
  logic signed [W:0]     o_data_q, o_data_d;
  logic [1:0]            o_phase_q, o_phase_d;
  logic                  o_uf_q, o_uf_d;

  logic                  ready_s;
  logic                  hs_s;
  logic [FW-1:0]         new_fac_s;
  logic [1:0]            phase_next_s;

  // Ready whenever idle, or on the last repeat of the sample being held.
  always_comb begin
    ready_s = (state_q == IDLE) || (cnt_q == (act_q - FW'(1)));
    hs_s    = bus.i_valid && ready_s;
  end

  // Next-state, hold/factor bookkeeping and registered-output precompute.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    act_d        = act_q;
    cnt_d        = cnt_q;
    hold_i_d     = hold_i_q;
    hold_q_d     = hold_q_q;
    o_valid_d    = 1'b0;
    o_data_d     = '0;
    o_phase_d    = 2'd0;
    o_uf_d       = 1'b0;
    phase_next_s = 2'd0;

    // A strobe coinciding with a handshake applies to that very sample.
    if (bus.i_interp_cmd_valid) begin
      new_fac_s = clamp_factor(bus.i_interp_cmd_data);
      pend_d    = new_fac_s;
    end else begin
      new_fac_s = pend_q;
    end

    if (hs_s) begin
      act_d    = new_fac_s;
      cnt_d    = '0;
      hold_i_d = bus.i_data_i;
      hold_q_d = bus.i_data_q;
    end else begin
      hold_i_d = hold_i_q;
    end

    case (state_q)
      IDLE: begin
        if (hs_s) begin
          state_d      = RUN;
          phase_next_s = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        phase_next_s = o_phase_q + 2'd1;
        if (hs_s) begin
          state_d = RUN;
        end else if (ready_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          o_uf_d  = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_q + FW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == RUN) begin
      o_valid_d = 1'b1;
      o_phase_d = phase_next_s;
      o_data_d  = lo_mix(hold_i_d, hold_q_d, phase_next_s);
    end else begin
      o_valid_d = 1'b0;
    end
  end

  // State and output registers; reset leaves both factors at the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_q    <= FAC_MAX;
      act_q     <= FAC_MAX;
      cnt_q     <= '0;
      hold_i_q  <= '0;
      hold_q_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_phase_q <= 2'd0;
      o_uf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      hold_i_q  <= hold_i_d;
      hold_q_q  <= hold_q_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_phase_q <= o_phase_d;
      o_uf_q    <= o_uf_d;
    end
  end

  assign bus.o_ready     = ready_s;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_data      = o_data_q;
  assign bus.o_lo_phase  = o_phase_q;
  assign bus.o_underflow = o_uf_q;

endmodule
